// File: rtl/bram_share_ctrl.sv
// Shared simple-dual-port BRAM front end: power-on/on-demand clear, one
// write pass-through client, two round-robin read clients, registered data.
//
// Ports:
//   CLK, RST            clock, async active-high reset
//   CLR / BUSY          clear request / clear pending or running
//   WREQ, WADR_I,
//   WDAT_I / WACK       write client request and same-cycle accept
//   RREQn, RADRn / RACKn read client n request and same-cycle grant
//   RVALIDn, RDAT_O     registered read data, tagged with owning client
//   RAM_*               connection to the inferred BRAM (1-cycle read)
`timescale 1ns/1ps
module bram_share_ctrl #(
  parameter int unsigned DBITS = 16,
  parameter int unsigned ABITS = 9,
  parameter logic [DBITS-1:0] CLR_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  output logic             BUSY,
  input  logic             WREQ,
  input  logic [ABITS-1:0] WADR_I,
  input  logic [DBITS-1:0] WDAT_I,
  output logic             WACK,
  input  logic             RREQ0,
  input  logic [ABITS-1:0] RADR0,
  output logic             RACK0,
  input  logic             RREQ1,
  input  logic [ABITS-1:0] RADR1,
  output logic             RACK1,
  output logic             RVALID0,
  output logic             RVALID1,
  output logic [DBITS-1:0] RDAT_O,
  output logic [ABITS-1:0] RAM_WADR,
  output logic [DBITS-1:0] RAM_WDAT,
  output logic             RAM_WEN,
  output logic [ABITS-1:0] RAM_RADR,
  output logic             RAM_REN,
  input  logic [DBITS-1:0] RAM_RDAT
);

  typedef enum logic [1:0] {
    START,
    CLEAR,
    RUN
  } state_t;

  // SIZE-1 is the all-ones address
  localparam logic [ABITS-1:0] LAST = '1;

  state_t           state, state_n;
  logic [ABITS-1:0] cnt, cnt_n;
  logic             lg;
  logic             tag0, tag1;
  logic             run;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= START;
      cnt     <= '0;
      lg      <= 1'b1;
      tag0    <= 1'b0;
      tag1    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDAT_O  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      if (RACK0 | RACK1)
        lg <= RACK1;
      // tag lines up with RAM_RDAT one cycle after the grant
      tag0    <= RACK0;
      tag1    <= RACK1;
      RVALID0 <= tag0;
      RVALID1 <= tag1;
      if (tag0 | tag1)
        RDAT_O <= RAM_RDAT;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    BUSY     = 1'b1;
    WACK     = 1'b0;
    RAM_WEN  = 1'b0;
    RAM_WADR = WADR_I;
    RAM_WDAT = WDAT_I;
    unique case (state)
      START: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
      CLEAR: begin
        RAM_WEN  = 1'b1;
        RAM_WADR = cnt;
        RAM_WDAT = CLR_VAL;
        if (CLR) begin
          cnt_n = '0;
        end else if (cnt == LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        BUSY    = 1'b0;
        WACK    = WREQ;
        RAM_WEN = WREQ;
        if (CLR) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = START;
        cnt_n   = '0;
      end
    endcase
  end

  assign run = (state == RUN);

  // on a tie the client that did not win last time is granted
  assign RACK0 = run & RREQ0 & (~RREQ1 | lg);
  assign RACK1 = run & RREQ1 & (~RREQ0 | ~lg);

  assign RAM_REN  = RACK0 | RACK1;
  assign RAM_RADR = RACK1 ? RADR1 : RADR0;

endmodule

// File: tb/tb_bram_share_ctrl.sv
// Scoreboard bench for bram_share_ctrl with a behavioural 1-cycle BRAM.
// Directed stimulus; read responses are checked by a separate monitor.
`timescale 1ns/1ps
module tb_bram_share_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLR = 1'b0;
  logic        BUSY;
  logic        WREQ = 1'b0;
  logic [8:0]  WADR_I = '0;
  logic [15:0] WDAT_I = '0;
  logic        WACK;
  logic        RREQ0 = 1'b0;
  logic [8:0]  RADR0 = '0;
  logic        RACK0;
  logic        RREQ1 = 1'b0;
  logic [8:0]  RADR1 = '0;
  logic        RACK1;
  logic        RVALID0, RVALID1;
  logic [15:0] RDAT_O;
  logic [8:0]  RAM_WADR;
  logic [15:0] RAM_WDAT;
  logic        RAM_WEN;
  logic [8:0]  RAM_RADR;
  logic        RAM_REN;
  logic [15:0] RAM_RDAT;

  bram_share_ctrl dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
    .WREQ(WREQ), .WADR_I(WADR_I), .WDAT_I(WDAT_I), .WACK(WACK),
    .RREQ0(RREQ0), .RADR0(RADR0), .RACK0(RACK0),
    .RREQ1(RREQ1), .RADR1(RADR1), .RACK1(RACK1),
    .RVALID0(RVALID0), .RVALID1(RVALID1), .RDAT_O(RDAT_O),
    .RAM_WADR(RAM_WADR), .RAM_WDAT(RAM_WDAT), .RAM_WEN(RAM_WEN),
    .RAM_RADR(RAM_RADR), .RAM_REN(RAM_REN), .RAM_RDAT(RAM_RDAT)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [512];
  always @(posedge CLK) begin
    if (RAM_WEN) mem[RAM_WADR] <= RAM_WDAT;
    RAM_RDAT <= mem[RAM_RADR];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        cl;
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t q [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST && (RVALID0 || RVALID1)) begin
      check("rvalid_excl", {31'd0, RVALID0 & RVALID1}, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got %b%b want none", RVALID1, RVALID0);
      end else begin
        e = q.pop_front();
        check("rv_client", {31'd0, RVALID1}, {31'd0, e.cl});
        check("rdat", {16'd0, RDAT_O}, {16'd0, e.d});
        check("rv_cycle", cyc, e.c);
      end
    end
  end

  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic cl, input logic [15:0] d);
    exp_t e;
    e.cl = cl;
    e.d  = d;
    e.c  = cyc + 2;
    q.push_back(e);
  endtask

  task automatic grant(input logic g0, input logic g1, input logic [15:0] d);
    @(negedge CLK);
    check("rack0", {31'd0, RACK0}, {31'd0, g0});
    check("rack1", {31'd0, RACK1}, {31'd0, g1});
    if (g0) push(1'b0, d);
    if (g1) push(1'b1, d);
  endtask

  task automatic measure(input int exp_busy, input string nm);
    int b = 0;
    int w = 0;
    int bad = 0;
    int ackbad = 0;
    int guard = 0;
    while (guard < 2000) begin
      @(negedge CLK);
      guard++;
      if (!BUSY) break;
      b++;
      if (RACK0 | RACK1 | WACK) ackbad++;
      if (RAM_WEN) begin
        if (RAM_WADR != w[8:0] || RAM_WDAT != 16'h0) bad++;
        w++;
      end
    end
    check({nm, "_busy_cycles"}, b, exp_busy);
    check({nm, "_wen_cycles"}, w, 512);
    check({nm, "_clr_addr_data"}, bad, 0);
    check({nm, "_acks_in_clear"}, ackbad, 0);
  endtask

  logic [8:0] radr_tab [4] = '{9'h005, 9'h010, 9'h020, 9'h021};

  initial begin
    int found;
    RREQ0 = 1; RREQ1 = 1; WREQ = 1;
    WADR_I = 9'h1FF; WDAT_I = 16'h0;
    RADR0 = 9'h1FF; RADR1 = 9'h1FE;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'd0, BUSY}, 1);
    check("rst_wen", {31'd0, RAM_WEN}, 0);
    check("rst_acks", {29'd0, RACK0, RACK1, WACK}, 0);
    check("rst_rvalid", {30'd0, RVALID0, RVALID1}, 0);
    check("rst_rdat", {16'd0, RDAT_O}, 0);

    go();
    RST = 0;
    measure(513, "init");
    check("first_rack0", {31'd0, RACK0}, 1);
    check("first_rack1", {31'd0, RACK1}, 0);
    check("first_wack", {31'd0, WACK}, 1);
    push(1'b0, 16'h0000);
    go();
    WREQ = 0; RREQ0 = 0; RREQ1 = 0;

    WREQ = 1; WADR_I = 9'h005; WDAT_I = 16'h1234;
    @(negedge CLK);
    check("wack", {31'd0, WACK}, 1);
    check("ram_wen", {31'd0, RAM_WEN}, 1);
    check("ram_wadr", {23'd0, RAM_WADR}, 9'h005);
    check("ram_wdat", {16'd0, RAM_WDAT}, 16'h1234);
    go();
    WREQ = 0; RREQ0 = 1; RADR0 = 9'h005;
    grant(1, 0, 16'h1234);
    go();
    RADR0 = 9'h006;
    grant(1, 0, 16'h0000);
    go();
    RREQ0 = 0;

    WREQ = 1; WADR_I = 9'h020; WDAT_I = 16'hA0A0;
    go();
    WADR_I = 9'h021; WDAT_I = 16'hB1B1;
    go();
    WREQ = 0; RREQ1 = 1; RADR1 = 9'h021;
    grant(0, 1, 16'hB1B1);
    check("ram_radr1", {23'd0, RAM_RADR}, 9'h021);
    check("ram_ren", {31'd0, RAM_REN}, 1);
    go();
    RREQ0 = 1; RADR0 = 9'h020;
    for (int i = 0; i < 6; i++) begin
      grant(i % 2 == 0, i % 2 == 1, (i % 2 == 0) ? 16'hA0A0 : 16'hB1B1);
      go();
    end
    RREQ0 = 0; RREQ1 = 0;

    WREQ = 1; WADR_I = 9'h010; WDAT_I = 16'hBEEF;
    RREQ0 = 1; RADR0 = 9'h010;
    grant(1, 0, 16'h0000);
    check("wack_same", {31'd0, WACK}, 1);
    go();
    WREQ = 0;
    grant(1, 0, 16'hBEEF);
    go();
    RREQ0 = 0;

    CLR = 1; RREQ1 = 1; RADR1 = 9'h010;
    grant(0, 1, 16'hBEEF);
    check("busy_run", {31'd0, BUSY}, 0);
    go();
    CLR = 0; RREQ1 = 0;
    measure(512, "clr");
    go();
    for (int i = 0; i < 4; i++) begin
      RREQ0 = 1; RADR0 = radr_tab[i];
      grant(1, 0, 16'h0000);
      go();
    end
    RREQ0 = 0;

    WREQ = 1; WADR_I = 9'h040; WDAT_I = 16'h7777;
    go();
    WREQ = 0; RREQ0 = 1; RADR0 = 9'h040;
    grant(1, 0, 16'h7777);
    go();
    RREQ0 = 0;
    repeat (3) go();
    @(negedge CLK);
    check("rdat_hold", {16'd0, RDAT_O}, 16'h7777);
    go();
    CLR = 1;
    go();
    CLR = 0;
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge CLK);
      if (RAM_WEN && RAM_WADR == 9'd200) found = 1;
    end
    check("reach_addr200", found, 1);
    #1 RST = 1;
    #1;
    check("arst_busy", {31'd0, BUSY}, 1);
    check("arst_wen", {31'd0, RAM_WEN}, 0);
    check("arst_rdat", {16'd0, RDAT_O}, 0);
    check("arst_rvalid", {30'd0, RVALID0, RVALID1}, 0);
    go();
    RST = 0;
    measure(513, "rst");
    go();
    RREQ0 = 1; RADR0 = 9'h040;
    grant(1, 0, 16'h0000);
    go();
    RREQ0 = 0;
    repeat (4) go();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
